// File: rtl/mpu_result_drain_if.sv
// Result stream from the drain block to the writeback path: one accumulator
// column per beat, carrying the raw value, its requantized byte and its column index.
interface mpu_result_drain_if #(
    parameter int N     = 4,
    parameter int ACC_W = 17
);
    localparam int IDX_W = $clog2(N);

    logic             m_valid;
    logic             m_ready;
    logic [ACC_W-1:0] m_data_raw;
    logic [7:0]       m_data_q;
    logic [IDX_W-1:0] m_idx;
    logic             m_last;

    modport master (
        output m_valid,
        output m_data_raw,
        output m_data_q,
        output m_idx,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data_raw,
        input  m_data_q,
        input  m_idx,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/mpu_result_drain.sv
// Waits a programmable delay after start, snapshots one row of MAC accumulators
// and streams them out column by column with a saturated 8-bit requantized copy.
module mpu_result_drain #(
    parameter int N     = 4,
    parameter int ACC_W = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          wait_cycles,
    input  logic [4:0]          shift,
    input  logic [N*ACC_W-1:0]  c_in,
    output logic                busy,
    output logic                done,
    mpu_result_drain_if.master  m
);
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       cnt;
    logic [4:0]       shift_r;
    logic [IDX_W-1:0] idx;
    logic [ACC_W-1:0] cap_buf [N];
    logic             done_r;
    logic             xfer;
    logic             final_xfer;
    logic [ACC_W-1:0] cur;
    logic [ACC_W-1:0] shifted;

    assign xfer       = (state == STREAM) && m.m_ready;
    assign final_xfer = xfer && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WAIT;
            WAIT:    if (cnt == 8'd0) state_nxt = STREAM;
            STREAM:  if (final_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The buffer is loaded only on the capture cycle, so later c_in activity
    // cannot leak into a stream that is already in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 8'd0;
            shift_r <= 5'd0;
            idx     <= '0;
            done_r  <= 1'b0;
            for (int j = 0; j < N; j++) begin
                cap_buf[j] <= '0;
            end
        end else begin
            done_r <= final_xfer;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= wait_cycles;
                        shift_r <= shift;
                    end
                end
                WAIT: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        idx <= '0;
                        for (int j = 0; j < N; j++) begin
                            cap_buf[j] <= c_in[j*ACC_W +: ACC_W];
                        end
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        idx <= final_xfer ? '0 : idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs come only from registered state, never from m_ready.
    always_comb begin
        cur     = cap_buf[idx];
        shifted = (int'(shift_r) >= ACC_W) ? '0 : (cur >> shift_r);

        busy         = (state != IDLE);
        done         = done_r;
        m.m_valid    = (state == STREAM);
        m.m_data_raw = '0;
        m.m_data_q   = 8'd0;
        m.m_idx      = '0;
        m.m_last     = 1'b0;
        if (state == STREAM) begin
            m.m_data_raw = cur;
            m.m_data_q   = (shifted > ACC_W'(255)) ? 8'hFF : shifted[7:0];
            m.m_idx      = idx;
            m.m_last     = (idx == LAST_IDX);
        end
    end
endmodule

// File: tb/tb_mpu_result_drain.sv
// Scenario bench for mpu_result_drain: expected beats are queued when a drain is
// started and compared as the stream hands them over.
module tb_mpu_result_drain;
    localparam int N     = 4;
    localparam int ACC_W = 17;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         wait_cycles;
    logic [4:0]         shift;
    logic [N*ACC_W-1:0] c_in;
    logic               busy;
    logic               done;

    mpu_result_drain_if #(.N(N), .ACC_W(ACC_W)) m_if ();

    mpu_result_drain #(.N(N), .ACC_W(ACC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .wait_cycles (wait_cycles),
        .shift       (shift),
        .c_in        (c_in),
        .busy        (busy),
        .done        (done),
        .m           (m_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int done_count = 0;

    logic [ACC_W-1:0] raw_q [$];
    logic [7:0]       q_q [$];
    int               idx_q [$];

    logic [ACC_W-1:0] e_raw;
    logic [7:0]       e_q;
    int               e_idx;
    int               n;
    int               guard;
    int               lat;
    int               dc0;

    always @(posedge clk) begin
        if (done === 1'b1) done_count <= done_count + 1;
    end

    function automatic logic [7:0] requant(input logic [ACC_W-1:0] c, input int sh);
        int v;
        if (sh >= ACC_W) return 8'd0;
        v = int'(c) >> sh;
        return (v > 255) ? 8'd255 : v[7:0];
    endfunction

    // Called right after a falling edge; holds start for one cycle and queues the expected beats.
    task automatic start_drain(input int wc, input int sh, input logic [ACC_W-1:0] c0,
                               input logic [ACC_W-1:0] c1, input logic [ACC_W-1:0] c2,
                               input logic [ACC_W-1:0] c3);
        logic [ACC_W-1:0] v [N];
        v[0] = c0; v[1] = c1; v[2] = c2; v[3] = c3;
        c_in        = {c3, c2, c1, c0};
        wait_cycles = wc[7:0];
        shift       = sh[4:0];
        start       = 1'b1;
        for (int j = 0; j < N; j++) begin
            raw_q.push_back(v[j]);
            q_q.push_back(requant(v[j], sh));
            idx_q.push_back(j);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        wait_cycles = 8'd0;
        shift = 5'd0;
        c_in = '0;
        m_if.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, m_if.m_valid, m_if.m_last} !== 4'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got=%b exp=0000", {busy, done, m_if.m_valid, m_if.m_last});
        end
        checks++;
        if ({m_if.m_data_raw, m_if.m_data_q, m_if.m_idx} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data raw=%0d q=%0d idx=%0d exp=0", m_if.m_data_raw, m_if.m_data_q, m_if.m_idx);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_basic();
        m_if.m_ready = 1'b1;
        dc0 = done_count;
        start_drain(3, 0, 17'd100, 17'd200, 17'd300, 17'd70000);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_busy got=%b exp=1", busy);
        end
        lat = 1;
        while (m_if.m_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 5) begin
            failures++;
            $display("[TB] FAIL basic_latency got=%0d exp=5", lat);
        end
        n = 0; guard = 0;
        while (n < N && guard < 40) begin
            if (m_if.m_valid && m_if.m_ready) begin
                e_raw = raw_q.pop_front(); e_q = q_q.pop_front(); e_idx = idx_q.pop_front();
                checks++;
                if (m_if.m_data_raw !== e_raw) begin
                    failures++;
                    $display("[TB] FAIL basic_raw idx=%0d got=%0d exp=%0d", e_idx, m_if.m_data_raw, e_raw);
                end
                checks++;
                if (m_if.m_data_q !== e_q) begin
                    failures++;
                    $display("[TB] FAIL basic_q idx=%0d got=%0d exp=%0d", e_idx, m_if.m_data_q, e_q);
                end
                checks++;
                if (m_if.m_idx !== e_idx[1:0] || m_if.m_last !== (e_idx == N-1)) begin
                    failures++;
                    $display("[TB] FAIL basic_idx got=%0d/%b exp=%0d/%b", m_if.m_idx, m_if.m_last, e_idx, e_idx == N-1);
                end
                n++;
            end
            @(negedge clk);
            guard++;
        end
        checks++;
        if (n != N || done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_done beats=%0d done=%b busy=%b exp=4/1/0", n, done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || done_count - dc0 != 1) begin
            failures++;
            $display("[TB] FAIL basic_done_pulse done=%b count=%0d exp=0/1", done, done_count - dc0);
        end
    endtask

    task automatic test_backpressure();
        int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        int k;
        bit hold;
        logic [28:0] snap;
        m_if.m_ready = 1'b0;
        start_drain(3, 0, 17'd100, 17'd200, 17'd300, 17'd70000);
        guard = 0;
        while (m_if.m_valid !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        k = 0; n = 0; guard = 0; hold = 0; snap = '0;
        while (n < N && guard < 40) begin
            if (hold) begin
                checks++;
                if ({m_if.m_valid, m_if.m_data_raw, m_if.m_data_q, m_if.m_idx, m_if.m_last} !== snap) begin
                    failures++;
                    $display("[TB] FAIL bp_hold got=%h exp=%h",
                             {m_if.m_valid, m_if.m_data_raw, m_if.m_data_q, m_if.m_idx, m_if.m_last}, snap);
                end
                hold = 0;
            end
            m_if.m_ready = pat[k % 7][0];
            k++;
            if (m_if.m_valid && m_if.m_ready) begin
                e_raw = raw_q.pop_front(); e_q = q_q.pop_front(); e_idx = idx_q.pop_front();
                checks++;
                if (m_if.m_data_raw !== e_raw || m_if.m_idx !== e_idx[1:0] || m_if.m_data_q !== e_q) begin
                    failures++;
                    $display("[TB] FAIL bp_beat got=%0d@%0d q=%0d exp=%0d@%0d q=%0d",
                             m_if.m_data_raw, m_if.m_idx, m_if.m_data_q, e_raw, e_idx, e_q);
                end
                n++;
            end else if (m_if.m_valid) begin
                snap = {m_if.m_valid, m_if.m_data_raw, m_if.m_data_q, m_if.m_idx, m_if.m_last};
                hold = 1;
            end
            @(negedge clk);
            guard++;
        end
        checks++;
        if (n != N || k != 7 || m_if.m_valid !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_count beats=%0d cycles=%0d valid=%b done=%b exp=4/7/0/1", n, k, m_if.m_valid, done);
        end
        m_if.m_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_requantize();
        m_if.m_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            if (r == 0) start_drain(0, 4, 17'd4096, 17'd4080, 17'd4079, 17'd15);
            else        start_drain(0, 20, 17'd131071, 17'd131071, 17'd131071, 17'd131071);
            n = 0; guard = 0;
            while (n < N && guard < 40) begin
                if (m_if.m_valid && m_if.m_ready) begin
                    e_raw = raw_q.pop_front(); e_q = q_q.pop_front(); e_idx = idx_q.pop_front();
                    checks++;
                    if (m_if.m_data_q !== e_q || m_if.m_data_raw !== e_raw) begin
                        failures++;
                        $display("[TB] FAIL requant r=%0d idx=%0d got=%0d/%0d exp=%0d/%0d",
                                 r, e_idx, m_if.m_data_q, m_if.m_data_raw, e_q, e_raw);
                    end
                    n++;
                end
                @(negedge clk);
                guard++;
            end
            checks++;
            if (n != N || done !== 1'b1) begin
                failures++;
                $display("[TB] FAIL requant_done r=%0d beats=%0d done=%b exp=4/1", r, n, done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_capture_isolation();
        m_if.m_ready = 1'b1;
        start_drain(0, 0, 17'd11, 17'd22, 17'd33, 17'd44);
        @(negedge clk);
        c_in = '1;
        checks++;
        if (m_if.m_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL iso_latency valid=%b exp=1", m_if.m_valid);
        end
        n = 0; guard = 0;
        while (n < N && guard < 40) begin
            if (m_if.m_valid && m_if.m_ready) begin
                e_raw = raw_q.pop_front(); e_q = q_q.pop_front(); e_idx = idx_q.pop_front();
                checks++;
                if (m_if.m_data_raw !== e_raw || m_if.m_idx !== e_idx[1:0]) begin
                    failures++;
                    $display("[TB] FAIL iso_raw idx=%0d got=%0d exp=%0d", e_idx, m_if.m_data_raw, e_raw);
                end
                n++;
            end
            @(negedge clk);
            guard++;
        end
        checks++;
        if (n != N || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL iso_done beats=%0d done=%b exp=4/1", n, done);
        end
        @(negedge clk);
    endtask

    task automatic test_start_handling();
        bit pulsed;
        m_if.m_ready = 1'b1;
        dc0 = done_count;
        start_drain(2, 0, 17'd5, 17'd6, 17'd7, 17'd8);
        start = 1'b1; wait_cycles = 8'd0; shift = 5'd3;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            pulsed = 0; n = 0; guard = 0;
            while (n < N && guard < 40) begin
                start = (r == 0 && n == 1 && !pulsed);
                if (start) pulsed = 1;
                if (m_if.m_valid && m_if.m_ready) begin
                    e_raw = raw_q.pop_front(); e_q = q_q.pop_front(); e_idx = idx_q.pop_front();
                    checks++;
                    if (m_if.m_data_raw !== e_raw || m_if.m_data_q !== e_q || m_if.m_idx !== e_idx[1:0]) begin
                        failures++;
                        $display("[TB] FAIL start_beat r=%0d got=%0d/%0d@%0d exp=%0d/%0d@%0d", r,
                                 m_if.m_data_raw, m_if.m_data_q, m_if.m_idx, e_raw, e_q, e_idx);
                    end
                    n++;
                end
                @(negedge clk);
                guard++;
            end
            start = 1'b0;
            checks++;
            if (n != N || done !== 1'b1) begin
                failures++;
                $display("[TB] FAIL start_done r=%0d beats=%0d done=%b exp=4/1", r, n, done);
            end
            if (r == 0) begin
                start_drain(0, 1, 17'd400, 17'd600, 17'd1000, 17'd9);
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL start_on_done busy=%b exp=1", busy);
                end
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done_count - dc0 != 2 || busy !== 1'b0 || m_if.m_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL start_ignored dones=%0d busy=%b valid=%b exp=2/0/0", done_count - dc0, busy, m_if.m_valid);
        end
    endtask

    task automatic test_reset_mid_stream();
        m_if.m_ready = 1'b1;
        start_drain(1, 0, 17'd1, 17'd2, 17'd3, 17'd4);
        n = 0; guard = 0;
        while (n < 2 && guard < 40) begin
            if (m_if.m_valid && m_if.m_ready) begin
                e_raw = raw_q.pop_front(); e_q = q_q.pop_front(); e_idx = idx_q.pop_front();
                n++;
            end
            @(negedge clk);
            guard++;
        end
        dc0 = done_count;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, m_if.m_valid, m_if.m_last, m_if.m_data_raw, m_if.m_data_q, m_if.m_idx} !== '0) begin
            failures++;
            $display("[TB] FAIL rst_mid outputs busy=%b valid=%b raw=%0d q=%0d idx=%0d exp=0",
                     busy, m_if.m_valid, m_if.m_data_raw, m_if.m_data_q, m_if.m_idx);
        end
        raw_q.delete(); q_q.delete(); idx_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (done_count != dc0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid_no_done dones=%0d busy=%b exp=0/0", done_count - dc0, busy);
        end
        start_drain(0, 2, 17'd1000, 17'd1023, 17'd1024, 17'd3);
        n = 0; guard = 0;
        while (n < N && guard < 40) begin
            if (m_if.m_valid && m_if.m_ready) begin
                e_raw = raw_q.pop_front(); e_q = q_q.pop_front(); e_idx = idx_q.pop_front();
                checks++;
                if (m_if.m_data_raw !== e_raw || m_if.m_data_q !== e_q || m_if.m_idx !== e_idx[1:0]) begin
                    failures++;
                    $display("[TB] FAIL rst_fresh got=%0d/%0d@%0d exp=%0d/%0d@%0d",
                             m_if.m_data_raw, m_if.m_data_q, m_if.m_idx, e_raw, e_q, e_idx);
                end
                n++;
            end
            @(negedge clk);
            guard++;
        end
        checks++;
        if (n != N || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_fresh_done beats=%0d done=%b exp=4/1", n, done);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_requantize();
        test_capture_isolation();
        test_start_handling();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mpu_result_drain.md
# mpu_result_drain

Result-side companion to the systolic MAC element array. It waits a programmable number of cycles after a compute start, then snapshots the N parallel 17-bit accumulator outputs from one row of MAC elements. It streams them out one column per beat over a valid/ready interface, with both the raw 17-bit value and a shifted, saturated unsigned 8-bit requantized value. It is the reader for the array's `c_calc` outputs, sitting between the array and the result writeback path.

## Interface

Parameters:
- `N`, 4: number of columns drained; N ≥ 2.
- `ACC_W`, 17: accumulator width from each MAC element.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a drain; honoured only in IDLE.
- `wait_cycles`  in  8  cycles to wait before capture; sampled with `start`.
- `shift`  in  5  right-shift for requantization; sampled with `start`.
- `c_in`  in  N*ACC_W  accumulators; column j at bits [j*ACC_W +: ACC_W].
- `busy`  out  1  high in WAIT and STREAM.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accepts the beat.
- `m_data_raw`  out  ACC_W  captured accumulator for the current column.
- `m_data_q`  out  8  requantized value for the current column.
- `m_idx`  out  $clog2(N)  current column index.
- `m_last`  out  1  high with the beat for column N-1.
- `done`  out  1  one-cycle pulse after the final transfer.

## Operation

- States are IDLE, WAIT and STREAM.
- **IDLE**
  - `start`=1 latches `wait_cycles` into a down-counter and `shift` into a register, then moves to WAIT.
- **WAIT**
  - When the counter is nonzero, it decrements.
  - When the counter is 0, the block captures all N columns of `c_in` into an internal buffer, sets idx=0 and moves to STREAM.
- **STREAM**
  - `m_valid`=1.
  - `m_data_raw` = buf[idx].
  - `m_data_q` = min(buf[idx] >> shift, 255), using a logical unsigned shift. Any shift ≥ ACC_W yields 0.
  - A transfer occurs on a cycle with `m_valid` && `m_ready`; it increments idx.
  - A transfer at idx=N-1 returns the block to IDLE and pulses `done` on the following cycle.
- `start` is ignored while `busy`=1. It is not queued.
- `start` on the cycle `done` is high is accepted, because the block is already in IDLE.
- Arithmetic is unsigned throughout, matching the zero-extended products of the MAC elements.
- The buffer is written only at capture. Changes on `c_in` after capture do not affect the stream.

## Timing

- Reset (`rst`=0, asynchronous):
  - State goes to IDLE; counter, idx and buffer go to 0.
  - `busy`, `m_valid`, `m_data_raw`, `m_data_q`, `m_idx`, `m_last` and `done` are all 0.
  - Reset mid-WAIT or mid-STREAM aborts the drain; no `done` is produced.
  - Leaving reset returns the block to IDLE.
- Capture timing, with `start` sampled at edge T:
  - `busy`=1 from T+1.
  - Capture happens at edge T+1+wait_cycles, so `c_in` is sampled during the cycle before that edge.
  - The first `m_valid` appears in the cycle after T+1+wait_cycles.
  - With wait_cycles=0, capture is at T+1 and `m_valid` rises after T+1.
- Throughput is one column per cycle when `m_ready`=1; a full drain of N columns takes N cycles.
- While `m_valid`=1 and `m_ready`=0, all `m_*` outputs are held stable.
- `m_valid` never drops without a transfer, except on reset.
- `done` is registered: it is high for exactly the one cycle after the final transfer, and `busy`=0 in that same cycle.
- `m_data_q` and `m_last` are derived combinationally from registered idx and buffer contents; no output depends on `m_ready` combinationally.

## Test plan

- **Basic drain:** N=4, wait_cycles=3, shift=0, c_in={100,200,300,70000}, `m_ready`=1.
  - `m_valid` first high 5 cycles after the `start` cycle.
  - raw = 100, 200, 300, 70000 on idx 0..3; q = 100, 200, 255, 255.
  - `m_last` on the 4th beat; `done` one cycle later.
- **Backpressure:** as above, with `m_ready` pattern 1,0,0,1,1,0,1.
  - Each beat is held stable while not ready.
  - Exactly 4 transfers occur, in order, with no duplicates.
- **Requantize edges:** shift=4.
  - c=4096 → q=255; c=4080 → q=255; c=4079 → q=254; c=15 → q=0.
  - shift=20 with c=131071 → q=0.
- **Capture isolation:** wait_cycles=0; change c_in to all-ones on the cycle after capture.
  - The stream still shows the pre-change values.
- **Start handling:**
  - `start` during WAIT/STREAM → ignored, and only one `done` is produced.
  - `start` on the `done` cycle → a new drain begins, with `busy`=1 next cycle.
- **Reset mid-stream:** assert `rst`=0 after 2 transfers.
  - All outputs go to 0 immediately, and no `done` is produced.
  - After release, a fresh `start` drains correctly from idx 0.
